// File: rtl/inst_mem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states, stream
// byte width and the NOP fill word that the instruction memory also uses.
package inst_mem_loader_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;

  // Power-on default of every instruction memory location.
  localparam logic [WORD_W-1:0] NOP_WORD = 16'b1000000001000000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_PAD,
    ST_FINISH
  } load_state_e;

  // States in which the loader consumes stream bytes.
  function automatic logic is_rx_state(load_state_e s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) ||
           (s == ST_DATA_HI) || (s == ST_DATA_LO);
  endfunction

endpackage

// File: rtl/inst_mem_loader_if.sv
// Byte stream (valid/ready) between the boot/UART source and the loader.
interface inst_mem_loader_if;
  import inst_mem_loader_pkg::*;

  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);

endinterface

// File: rtl/inst_word_assembler.sv
// Pairs consecutive stream bytes (high first) into a 16-bit word; word_valid
// pulses combinationally with the low-byte transfer so the caller acts on that edge.
module inst_word_assembler
  import inst_mem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  logic              phase_reg;
  logic [BYTE_W-1:0] hi_reg;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      phase_reg <= 1'b0;
      hi_reg    <= '0;
    end else if (byte_valid) begin
      phase_reg <= ~phase_reg;
      if (!phase_reg) begin
        hi_reg <= byte_data;
      end
    end
  end

  assign word_valid = byte_valid && phase_reg;
  assign word       = {hi_reg, byte_data};

endmodule

// File: rtl/inst_mem_loader.sv
// Loads a length-prefixed big-endian program from a byte stream into the
// instruction memory, NOP-pads the remainder and stalls the core meanwhile.
module inst_mem_loader
  import inst_mem_loader_pkg::*;
#(
  parameter int              WORD   = WORD_W,
  parameter int              LENGTH = 1024,
  parameter int              PCL    = 10,
  parameter logic [WORD-1:0] NOP    = NOP_WORD
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  inst_mem_loader_if.slave rx,
  output logic            mem_we,
  output logic [PCL-1:0]  mem_addr,
  output logic [WORD-1:0] mem_wdata,
  output logic            cpu_hold,
  output logic            done,
  output logic            error
);

  // One extra bit so the counter can reach LENGTH without wrapping.
  localparam int               CNT_W     = PCL + 1;
  localparam logic [15:0]      LEN_MAX   = 16'(LENGTH);
  localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(LENGTH - 1);

  load_state_e      state_reg, state_next;
  logic [15:0]      len_reg, len_next;
  logic [CNT_W-1:0] addr_reg, addr_next;
  logic [CNT_W-1:0] addr_inc;
  logic             mem_we_reg, mem_we_next;
  logic [PCL-1:0]   mem_addr_reg, mem_addr_next;
  logic [WORD-1:0]  mem_wdata_reg, mem_wdata_next;
  logic             cpu_hold_reg, cpu_hold_next;
  logic             done_reg, done_next;
  logic             error_reg, error_next;

  logic              rx_ready_int;
  logic              xfer;
  logic              asm_clear;
  logic              word_valid;
  logic [WORD_W-1:0] word;

  assign rx_ready_int = is_rx_state(state_reg);
  assign xfer         = rx.rx_valid && rx_ready_int;
  assign addr_inc     = addr_reg + CNT_W'(1);

  inst_word_assembler u_assembler (
    .clk        (clk),
    .rst        (rst),
    .clear      (asm_clear),
    .byte_valid (xfer),
    .byte_data  (rx.rx_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      len_reg       <= '0;
      addr_reg      <= '0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      cpu_hold_reg  <= 1'b0;
      done_reg      <= 1'b0;
      error_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      len_reg       <= len_next;
      addr_reg      <= addr_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      cpu_hold_reg  <= cpu_hold_next;
      done_reg      <= done_next;
      error_reg     <= error_next;
    end
  end

  // The address counter doubles as the loaded-word count while in DATA states.
  always_comb begin
    state_next     = state_reg;
    len_next       = len_reg;
    addr_next      = addr_reg;
    mem_we_next    = 1'b0;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    cpu_hold_next  = cpu_hold_reg;
    done_next      = done_reg;
    error_next     = error_reg;
    asm_clear      = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next    = ST_LEN_HI;
          cpu_hold_next = 1'b1;
          done_next     = 1'b0;
          error_next    = 1'b0;
          addr_next     = '0;
          asm_clear     = 1'b1;
        end
      end
      ST_LEN_HI: begin
        if (xfer) state_next = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (word_valid) begin
          len_next = word;
          if (word > LEN_MAX) begin
            error_next    = 1'b1;
            cpu_hold_next = 1'b0;
            state_next    = ST_IDLE;
          end else if (word == 16'd0) begin
            state_next = ST_PAD;
          end else begin
            state_next = ST_DATA_HI;
          end
        end
      end
      ST_DATA_HI: begin
        if (xfer) state_next = ST_DATA_LO;
      end
      ST_DATA_LO: begin
        if (word_valid) begin
          mem_we_next    = 1'b1;
          mem_addr_next  = addr_reg[PCL-1:0];
          mem_wdata_next = word;
          addr_next      = addr_inc;
          if (addr_inc == len_reg[CNT_W-1:0]) begin
            state_next = (len_reg < LEN_MAX) ? ST_PAD : ST_FINISH;
          end else begin
            state_next = ST_DATA_HI;
          end
        end
      end
      ST_PAD: begin
        mem_we_next    = 1'b1;
        mem_addr_next  = addr_reg[PCL-1:0];
        mem_wdata_next = NOP;
        addr_next      = addr_inc;
        if (addr_reg == LAST_ADDR) state_next = ST_FINISH;
      end
      ST_FINISH: begin
        cpu_hold_next = 1'b0;
        done_next     = 1'b1;
        state_next    = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign rx.rx_ready = rx_ready_int;
  assign mem_we      = mem_we_reg;
  assign mem_addr    = mem_addr_reg;
  assign mem_wdata   = mem_wdata_reg;
  assign cpu_hold    = cpu_hold_reg;
  assign done        = done_reg;
  assign error       = error_reg;

endmodule
